// File: rtl/serial_tx.sv
// Asynchronous serial transmitter: buffers host bytes in a small FIFO and shifts
// them out LSB-first as start/data/stop frames, paced by a sampled baud clock.
module serial_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_clk,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nxt;
    logic                 baud_q;
    logic                 tick;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] sh, sh_nxt;
    logic [3:0]           bitcnt, bitcnt_nxt;
    logic [1:0]           stopcnt, stopcnt_nxt;
    logic                 txd_nxt;
    logic                 do_write, do_pop, have_data;

    assign tick      = baud_clk & ~baud_q;
    assign have_data = (fifo_count != '0);
    assign wr_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign do_write  = wr_valid & wr_ready;
    assign busy      = (state != IDLE) | have_data;

    always_ff @(posedge clk) begin
        if (reset) baud_q <= 1'b0;
        else       baud_q <= baud_clk;
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_write, do_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                IDLE:    if (have_data) state_nxt = START;
                START:   state_nxt = DATA;
                DATA:    if (bitcnt == 4'(DATA_BITS)) state_nxt = STOP;
                STOP:    if (stopcnt >= 2'(STOP_BITS)) state_nxt = have_data ? START : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Leaving STOP with data queued goes straight into the next start bit.
    always_comb begin
        do_pop      = 1'b0;
        txd_nxt     = txd;
        sh_nxt      = sh;
        bitcnt_nxt  = bitcnt;
        stopcnt_nxt = stopcnt;
        if (tick) begin
            case (state)
                IDLE: begin
                    txd_nxt = 1'b1;
                    if (have_data) begin
                        do_pop  = 1'b1;
                        sh_nxt  = mem[rd_ptr];
                        txd_nxt = 1'b0;
                    end
                end
                START: begin
                    txd_nxt    = sh[0];
                    sh_nxt     = sh >> 1;
                    bitcnt_nxt = 4'd1;
                end
                DATA: begin
                    if (bitcnt == 4'(DATA_BITS)) begin
                        txd_nxt     = 1'b1;
                        stopcnt_nxt = 2'd1;
                    end else begin
                        txd_nxt    = sh[0];
                        sh_nxt     = sh >> 1;
                        bitcnt_nxt = bitcnt + 4'd1;
                    end
                end
                STOP: begin
                    txd_nxt = 1'b1;
                    if (stopcnt < 2'(STOP_BITS)) begin
                        stopcnt_nxt = stopcnt + 2'd1;
                    end else if (have_data) begin
                        do_pop  = 1'b1;
                        sh_nxt  = mem[rd_ptr];
                        txd_nxt = 1'b0;
                    end
                end
                default: txd_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txd     <= 1'b1;
            sh      <= '0;
            bitcnt  <= '0;
            stopcnt <= '0;
        end else begin
            txd     <= txd_nxt;
            sh      <= sh_nxt;
            bitcnt  <= bitcnt_nxt;
            stopcnt <= stopcnt_nxt;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance with 1 stop bit, one with 2 stop bits.
module tb_serial_tx;

    logic       clk, reset, baud_clk, baud_run;
    logic [7:0] wr_data;
    logic       wr_valid, wr_valid2;
    logic       wr_ready, txd, busy;
    logic [2:0] fifo_count;
    logic       wr_ready2, txd2, busy2;
    logic [2:0] fifo_count2;

    int         vecCount  = 0;
    int         missCount = 0;
    logic [7:0] expBytes[$];
    logic       bitVal, prevBusy;
    bit         gotReady;

    serial_tx #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .baud_clk(baud_clk),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .txd(txd), .busy(busy), .fifo_count(fifo_count)
    );

    serial_tx #(.DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .baud_clk(baud_clk),
        .wr_data(wr_data), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
        .txd(txd2), .busy(busy2), .fifo_count(fifo_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud clock toggles on clk falling edges, 16 clk cycles per bit period.
    initial begin
        baud_clk = 1'b0;
        #10;
        forever begin
            if (baud_run) baud_clk = ~baud_clk;
            #80;
        end
    end

    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input int which);
        wr_data = d;
        if (which == 0) wr_valid = 1'b1;
        else            wr_valid2 = 1'b1;
        tickClk();
        wr_valid  = 1'b0;
        wr_valid2 = 1'b0;
    endtask

    // Samples txd just after a falling baud edge, mid-way through a bit period.
    task automatic sampleBit(output logic b, input int which);
        logic prev;
        bit   seen;
        seen = 0;
        prev = baud_clk;
        for (int i = 0; i < 40 && !seen; i++) begin
            tickClk();
            if (prev && !baud_clk) seen = 1;
            prev = baud_clk;
        end
        if (!seen) begin
            missCount++;
            $display("[TB] FAIL baud_fall_timeout: observed no falling baud edge, required one within 40 cycles");
        end
        b = (which == 0) ? txd : txd2;
    endtask

    task automatic waitRise(input int which, output logic pb);
        logic prev;
        bit   seen;
        seen = 0;
        prev = baud_clk;
        pb   = (which == 0) ? busy : busy2;
        for (int i = 0; i < 40 && !seen; i++) begin
            tickClk();
            if (!prev && baud_clk) seen = 1;
            else begin
                prev = baud_clk;
                pb   = (which == 0) ? busy : busy2;
            end
        end
        if (!seen) begin
            missCount++;
            $display("[TB] FAIL baud_rise_timeout: observed no rising baud edge, required one within 40 cycles");
        end
    endtask

    // Consumes expBytes; every byte must already be queued before the first start bit.
    task automatic checkStream(input string tag, input int which, input int stopBits);
        logic       b, pb;
        logic [7:0] d;
        int         n;
        n = expBytes.size();
        for (int k = 0; k < n; k++) begin
            d = expBytes.pop_front();
            sampleBit(b, which);
            checkOutput({tag, "_start"}, b, 0);
            checkOutput({tag, "_count"}, (which == 0) ? fifo_count : fifo_count2, n - 1 - k);
            for (int i = 0; i < 8; i++) begin
                sampleBit(b, which);
                checkOutput({tag, "_data"}, b, d[i]);
            end
            for (int s = 0; s < stopBits; s++) begin
                sampleBit(b, which);
                checkOutput({tag, "_stop"}, b, 1);
            end
        end
        waitRise(which, pb);
        checkOutput({tag, "_busy_before_idle"}, pb, 1);
        checkOutput({tag, "_busy_idle"}, (which == 0) ? busy : busy2, 0);
        checkOutput({tag, "_txd_idle"}, (which == 0) ? txd : txd2, 1);
    endtask

    initial begin
        reset     = 1'b1;
        baud_run  = 1'b1;
        wr_data   = 8'h00;
        wr_valid  = 1'b0;
        wr_valid2 = 1'b0;
        repeat (3) tickClk();
        reset = 1'b0;

        $display("[TB] test 1: reset and idle line");
        checkOutput("rst_txd", txd, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wr_ready", wr_ready, 1);
        checkOutput("rst_count", fifo_count, 0);
        for (int i = 0; i < 20; i++) begin
            sampleBit(bitVal, 0);
            checkOutput("idle_txd", bitVal, 1);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_wr_ready", wr_ready, 1);
            checkOutput("idle_count", fifo_count, 0);
        end

        $display("[TB] test 2: single byte 0x55");
        applyStimulus(8'h55, 0);
        checkOutput("t2_count_after_write", fifo_count, 1);
        checkOutput("t2_busy_after_write", busy, 1);
        expBytes = '{8'h55};
        checkStream("t2", 0, 1);

        $display("[TB] test 3: back-to-back frames");
        sampleBit(bitVal, 0);
        applyStimulus(8'hA3, 0);
        applyStimulus(8'h0F, 0);
        applyStimulus(8'hFF, 0);
        checkOutput("t3_count_queued", fifo_count, 3);
        expBytes = '{8'hA3, 8'h0F, 8'hFF};
        checkStream("t3", 0, 1);

        $display("[TB] test 4: FIFO full with baud stopped");
        baud_run = 1'b0;
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        checkOutput("t4_ready_at_3", wr_ready, 1);
        applyStimulus(8'h44, 0);
        checkOutput("t4_ready_full", wr_ready, 0);
        checkOutput("t4_count_full", fifo_count, 4);
        applyStimulus(8'h99, 0);
        checkOutput("t4_count_rejected", fifo_count, 4);
        checkOutput("t4_txd_frozen", txd, 1);
        checkOutput("t4_busy_full", busy, 1);
        repeat (40) tickClk();
        checkOutput("t4_txd_still_frozen", txd, 1);
        checkOutput("t4_count_still_full", fifo_count, 4);
        baud_run = 1'b1;
        gotReady = 0;
        for (int i = 0; i < 60 && !gotReady; i++) begin
            tickClk();
            if (wr_ready) gotReady = 1;
        end
        if (!gotReady) begin
            missCount++;
            $display("[TB] FAIL t4_ready_timeout: observed wr_ready 0, required 1 within 60 cycles");
        end
        checkOutput("t4_txd_start_with_ready", txd, 0);
        checkOutput("t4_count_after_pop", fifo_count, 3);
        expBytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        checkStream("t4", 0, 1);

        $display("[TB] test 5: reset mid-frame");
        sampleBit(bitVal, 0);
        applyStimulus(8'h81, 0);
        applyStimulus(8'h5A, 0);
        applyStimulus(8'h3C, 0);
        checkOutput("t5_count_queued", fifo_count, 3);
        sampleBit(bitVal, 0);
        checkOutput("t5_start", bitVal, 0);
        sampleBit(bitVal, 0);
        checkOutput("t5_bit0", bitVal, 1);
        sampleBit(bitVal, 0);
        checkOutput("t5_bit1", bitVal, 0);
        sampleBit(bitVal, 0);
        checkOutput("t5_bit2", bitVal, 0);
        waitRise(0, prevBusy);
        checkOutput("t5_busy_in_frame", prevBusy, 1);
        tickClk();
        tickClk();
        checkOutput("t5_bit3", txd, 0);
        reset = 1'b1;
        tickClk();
        checkOutput("t5_txd_after_reset", txd, 1);
        checkOutput("t5_count_after_reset", fifo_count, 0);
        checkOutput("t5_busy_after_reset", busy, 0);
        checkOutput("t5_ready_after_reset", wr_ready, 1);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sampleBit(bitVal, 0);
            checkOutput("t5_no_frames", bitVal, 1);
            checkOutput("t5_busy_quiet", busy, 0);
        end

        $display("[TB] test 6: two stop bits");
        sampleBit(bitVal, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h01, 1);
        checkOutput("t6_count_queued", fifo_count2, 2);
        expBytes = '{8'h00, 8'h01};
        checkStream("t6", 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
